// File: rtl/core_mem_pkg.sv
// Shared definitions for the main-memory arbiter: default widths, arbitration
// limits, the owner encoding and a single-request view of the memory port.
package core_mem_pkg;

  localparam int DEF_ADDR_W          = 8;
  localparam int DEF_DATA_W          = 16;
  localparam int DEF_MAX_CORE_STREAK = 4;
  localparam int DEF_MAX_LOCK        = 8;
  localparam int STAT_W              = 16;

  // Owner of the memory port; the arbiter state is the owner of the previous cycle.
  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CORE,
    OWN_DMA
  } owner_e;

  // One access presented to main memory at the default widths.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// Grant decision for the main-memory arbiter. Tracks the previous owner, the
// run of core grants made while DMA waits, and the length of a locked DMA burst.
// Grants are combinational so the winner's access happens in the same cycle.
module mem_arb_fsm
  import core_mem_pkg::*;
#(
  parameter int MAX_CORE_STREAK = DEF_MAX_CORE_STREAK,
  parameter int MAX_LOCK        = DEF_MAX_LOCK
) (
  input  logic clk,
  input  logic reset,
  input  logic core_req,
  input  logic dma_req,
  input  logic dma_lock,
  output logic core_gnt,
  output logic dma_gnt
);

  localparam int STREAK_W = $clog2(MAX_CORE_STREAK + 1);
  localparam int LOCK_W   = $clog2(MAX_LOCK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CORE_STREAK);
  localparam logic [LOCK_W-1:0]   LOCK_MAX   = LOCK_W'(MAX_LOCK);

  owner_e              state;
  owner_e              grant;
  logic [STREAK_W-1:0] streak;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                lock_hold;

  // A locked DMA burst may keep the port only while it owned the previous cycle
  // and has not yet used up its burst allowance.
  assign lock_hold = (state == OWN_DMA) && dma_lock && dma_req && (lock_cnt < LOCK_MAX);

  // Priority: locked DMA burst, starved DMA, core, then plain DMA.
  always_comb begin
    // NOTE: default assignment first so every path drives grant and no latch is inferred.
    grant = OWN_IDLE;
    if (lock_hold) begin
      grant = OWN_DMA;
    end else if (dma_req && (streak == STREAK_MAX)) begin
      grant = OWN_DMA;
    end else if (core_req) begin
      grant = OWN_CORE;
    end else if (dma_req) begin
      grant = OWN_DMA;
    end
  end

  // Nobody is granted while reset is held, whatever the requesters do.
  assign core_gnt = reset && (grant == OWN_CORE);
  assign dma_gnt  = reset && (grant == OWN_DMA);

  // Owner state plus the core-streak and lock-burst counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= OWN_IDLE;
      streak   <= '0;
      lock_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state <= grant;

      if ((grant == OWN_DMA) || !dma_req) begin
        streak <= '0;
      end else if ((grant == OWN_CORE) && (streak != STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end

      // A burst that reached its limit restarts at zero even if DMA keeps the port.
      if (lock_hold) begin
        lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/main_memory_arbiter.sv
// Shares the single main-memory port between the core data port and the
// DMA/loader port. Core has priority; DMA is guaranteed progress and may lock
// the port for short bursts. Read data returns one cycle later in per-requester
// registers.
// Optional build macro MEM_ARB_STATS_EN adds saturating grant/conflict counters;
// without it the stat_* outputs are tied to zero.
module main_memory_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_CORE_STREAK = DEF_MAX_CORE_STREAK,
  parameter int MAX_LOCK        = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_core_gnt,
  output logic [STAT_W-1:0] stat_dma_gnt,
  output logic [STAT_W-1:0] stat_conflict
);

  mem_arb_fsm #(
    .MAX_CORE_STREAK(MAX_CORE_STREAK),
    .MAX_LOCK       (MAX_LOCK)
  ) u_fsm (
    .clk     (clk),
    .reset   (reset),
    .core_req(core_req),
    .dma_req (dma_req),
    .dma_lock(dma_lock),
    .core_gnt(core_gnt),
    .dma_gnt (dma_gnt)
  );

  // With no grant the address/data simply follow the core; only mem_we matters.
  assign mem_addr  = dma_gnt ? dma_addr  : core_addr;
  assign mem_wdata = dma_gnt ? dma_wdata : core_wdata;
  assign mem_we    = reset && ((core_gnt && core_we) || (dma_gnt && dma_we));

  // Capture read data for whichever requester read this cycle; rvalid pulses once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the read-data registers are reset because their value is visible at the ports.
      core_rdata  <= '0;
      core_rvalid <= 1'b0;
      dma_rdata   <= '0;
      dma_rvalid  <= 1'b0;
    end else begin
      core_rvalid <= core_gnt && !core_we;
      dma_rvalid  <= dma_gnt && !dma_we;
      if (core_gnt && !core_we) begin
        core_rdata <= mem_rdata;
      end
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Saturating usage counters: grants per requester and cycles with both requesting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_core_gnt <= '0;
      stat_dma_gnt  <= '0;
      stat_conflict <= '0;
    end else begin
      if (core_gnt && (stat_core_gnt != '1)) begin
        stat_core_gnt <= stat_core_gnt + 1'b1;
      end
      if (dma_gnt && (stat_dma_gnt != '1)) begin
        stat_dma_gnt <= stat_dma_gnt + 1'b1;
      end
      if (core_req && dma_req && (stat_conflict != '1)) begin
        stat_conflict <= stat_conflict + 1'b1;
      end
    end
  end
`else
  assign stat_core_gnt = '0;
  assign stat_dma_gnt  = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter. A behavioural main memory preloaded
// with 0xA000|addr sits on the memory port. Inputs change 1 ns after the rising
// edge; grants and read-back are sampled on the falling edge.
module tb_main_memory_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, dma_req, dma_we, dma_lock;
  logic [AW-1:0] core_addr, dma_addr, mem_addr;
  logic [DW-1:0] core_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] core_rdata, dma_rdata;
  logic          core_gnt, core_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [15:0]   stat_core_gnt, stat_dma_gnt, stat_conflict;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [256];
  logic          preload;

  always #5 clk = ~clk;

  // Main memory: asynchronous read, write on the rising edge, preload on demand.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  main_memory_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_gnt     (core_gnt),
    .core_rdata   (core_rdata),
    .core_rvalid  (core_rvalid),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_lock     (dma_lock),
    .dma_gnt      (dma_gnt),
    .dma_rdata    (dma_rdata),
    .dma_rvalid   (dma_rvalid),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .stat_core_gnt(stat_core_gnt),
    .stat_dma_gnt (stat_dma_gnt),
    .stat_conflict(stat_conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    dma_lock = 1'b0;
  endtask

  task automatic core_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic dma_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic lock);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d; dma_lock = lock;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_core_seq;

  initial begin
    idle_inputs();
    reset   = 1'b0;
    preload = 1'b1;
    // A core write is requested during reset and must never reach memory.
    core_set(1'b1, 1'b1, 8'h31, 16'hDEAD);
    repeat (2) next_cycle();
    preload = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_core_gnt",    32'(core_gnt),    32'h0);
    check("rst_dma_gnt",     32'(dma_gnt),     32'h0);
    check("rst_mem_we",      32'(mem_we),      32'h0);
    check("rst_core_rvalid", 32'(core_rvalid), 32'h0);
    check("rst_dma_rvalid",  32'(dma_rvalid),  32'h0);
    check("rst_core_rdata",  32'(core_rdata),  32'h0);
    check("rst_dma_rdata",   32'(dma_rdata),   32'h0);
    check("rst_stat_core",   32'(stat_core_gnt), 32'h0);
    idle_inputs();
    reset = 1'b1;
    next_cycle();

    // ---------------- streak: C,C,C,C,D,C,C,C,C,D ----------------
    exp_core_seq = 10'b0111101111;
    for (int i = 0; i < 10; i++) begin
      core_set(1'b1, 1'b0, 8'h40, 16'h0);
      dma_set(1'b1, 1'b0, 8'h41, 16'h0, 1'b0);
      @(negedge clk);
      check($sformatf("streak_core_gnt[%0d]", i), 32'(core_gnt), 32'(exp_core_seq[i]));
      check($sformatf("streak_dma_gnt[%0d]", i),  32'(dma_gnt),  32'(!exp_core_seq[i]));
      if (i > 0) begin
        check($sformatf("streak_core_rvalid[%0d]", i), 32'(core_rvalid), 32'(exp_core_seq[i-1]));
        check($sformatf("streak_dma_rvalid[%0d]", i),  32'(dma_rvalid),  32'(!exp_core_seq[i-1]));
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("streak_dma_rvalid_last", 32'(dma_rvalid), 32'h1);
    check("streak_dma_rdata_last",  32'(dma_rdata),  32'hA041);
    check("streak_core_rdata",      32'(core_rdata), 32'hA040);
`ifdef MEM_ARB_STATS_EN
    check("stat_core_gnt", 32'(stat_core_gnt), 32'd8);
    check("stat_dma_gnt",  32'(stat_dma_gnt),  32'd2);
    check("stat_conflict", 32'(stat_conflict), 32'd10);
`else
    check("stat_core_gnt_off", 32'(stat_core_gnt), 32'd0);
    check("stat_dma_gnt_off",  32'(stat_dma_gnt),  32'd0);
    check("stat_conflict_off", 32'(stat_conflict), 32'd0);
`endif
    next_cycle();

    // ---------------- locked DMA burst vs waiting core ----------------
    // Cycle 0 DMA takes the idle port; cycles 1..8 are the locked burst, the
    // core wins cycle 9 and then stops requesting, DMA resumes in 10 and 11.
    for (int i = 0; i < 12; i++) begin
      dma_set(1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b1);
      core_set((i >= 1) && (i <= 9), 1'b0, 8'h20, 16'h0);
      @(negedge clk);
      check($sformatf("lock_core_gnt[%0d]", i), 32'(core_gnt), 32'(i == 9));
      check($sformatf("lock_dma_gnt[%0d]", i),  32'(dma_gnt),  32'(i != 9));
      check($sformatf("lock_mem_we[%0d]", i),   32'(mem_we),   32'(i != 9));
      if (i >= 1) check($sformatf("lock_dma_rvalid[%0d]", i), 32'(dma_rvalid), 32'h0);
      if (i == 10) begin
        check("lock_core_rvalid", 32'(core_rvalid), 32'h1);
        check("lock_core_rdata",  32'(core_rdata),  32'hBEEF);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // ---------------- core write then DMA read of the same word ----------------
    core_set(1'b1, 1'b1, 8'h05, 16'h1234);
    dma_set(1'b1, 1'b0, 8'h05, 16'h0, 1'b0);
    @(negedge clk);
    check("wr_core_gnt",  32'(core_gnt),  32'h1);
    check("wr_dma_gnt",   32'(dma_gnt),   32'h0);
    check("wr_mem_we",    32'(mem_we),    32'h1);
    check("wr_mem_addr",  32'(mem_addr),  32'h05);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    next_cycle();
    core_set(1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    check("rd_dma_gnt", 32'(dma_gnt), 32'h1);
    check("rd_mem_we",  32'(mem_we),  32'h0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rd_dma_rvalid",  32'(dma_rvalid),  32'h1);
    check("rd_dma_rdata",   32'(dma_rdata),   32'h1234);
    check("rd_core_rvalid", 32'(core_rvalid), 32'h0);
    next_cycle();

    // ---------------- core-only back-to-back reads 0x10..0x13 ----------------
    for (int i = 0; i < 4; i++) begin
      core_set(1'b1, 1'b0, 8'h10 + 8'(i), 16'h0);
      @(negedge clk);
      check($sformatf("core_rd_gnt[%0d]", i),  32'(core_gnt), 32'h1);
      check($sformatf("core_rd_addr[%0d]", i), 32'(mem_addr), 32'h10 + 32'(i));
      if (i > 0) begin
        check($sformatf("core_rd_rvalid[%0d]", i), 32'(core_rvalid), 32'h1);
        check($sformatf("core_rd_rdata[%0d]", i),  32'(core_rdata),  32'hA010 + 32'(i - 1));
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("core_rd_rvalid_last", 32'(core_rvalid), 32'h1);
    check("core_rd_rdata_last",  32'(core_rdata),  32'hA013);
    next_cycle();
    @(negedge clk);
    check("core_rd_rvalid_drop", 32'(core_rvalid), 32'h0);
    next_cycle();

    // ---------------- reset in the middle of a locked DMA read ----------------
    dma_set(1'b1, 1'b0, 8'h50, 16'h0, 1'b1);
    @(negedge clk);
    check("mid_dma_gnt0", 32'(dma_gnt), 32'h1);
    next_cycle();
    core_set(1'b1, 1'b1, 8'h31, 16'hDEAD);
    @(negedge clk);
    check("mid_dma_gnt1",    32'(dma_gnt),    32'h1);
    check("mid_dma_rvalid1", 32'(dma_rvalid), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_dma_gnt",    32'(dma_gnt),    32'h0);
    check("mid_rst_core_gnt",   32'(core_gnt),   32'h0);
    check("mid_rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
    check("mid_rst_mem_we",     32'(mem_we),     32'h0);
    next_cycle();
    check("mid_rst_mem_we_edge", 32'(mem_we),     32'h0);
    check("mid_rst_rvalid_edge", 32'(dma_rvalid), 32'h0);
    @(negedge clk);
    core_set(1'b1, 1'b0, 8'h31, 16'h0);
    dma_set(1'b1, 1'b0, 8'h50, 16'h0, 1'b1);
    reset = 1'b1;
    #1;
    check("post_rst_core_gnt", 32'(core_gnt), 32'h1);
    check("post_rst_dma_gnt",  32'(dma_gnt),  32'h0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("post_rst_core_rvalid", 32'(core_rvalid), 32'h1);
    check("post_rst_no_write",    32'(core_rdata),  32'hA031);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
